mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester (icache = 0, dcache = 1) arbiter for a single-ported main
//   memory. One line transaction is in flight at a time. Ties go round-robin.
//   Every transaction completes with a one-cycle req_resp pulse. A timed-out
//   transaction also pulses req_err.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_read/req_write[1:0]  per-requester level-held read / write-back request
//   req_addr0/1, req_wdata0/1  per-requester line address / write line
//   req_resp[1:0]            one-cycle completion pulse for the granted requester
//   req_rdata                read line, valid while req_resp is high
//   req_err                  one-cycle pulse with req_resp on timeout
//   mem_read/mem_write       one-cycle command to main memory
//   mem_addr/mem_wdata       address / write line latched at grant
//   mem_resp, mem_rdata      main memory completion pulse and read line
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_read,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [LINE_W-1:0] req_wdata0,
  input  logic [LINE_W-1:0] req_wdata1,
  output logic [1:0]        req_resp,
  output logic [LINE_W-1:0] req_rdata,
  output logic              req_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [2:0]       state;
  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       pending;
  logic             pick;

  assign pending = req_read | req_write;

  // Requester 1 wins when it is the only one pending, or on a tie when
  // requester 0 was served last.
  always_comb begin
    pick = 1'b0;
    if (pending[1] && (!pending[0] || !last_grant)) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      req_resp   <= 2'b00;
      req_err    <= 1'b0;
      req_rdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Command and completion outputs are single-cycle pulses by default.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      req_resp  <= 2'b00;
      req_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|pending) begin
            grant     <= pick;
            mem_addr  <= pick ? req_addr1  : req_addr0;
            mem_wdata <= pick ? req_wdata1 : req_wdata0;
            // The command is registered here so it is high during ISSUE.
            // A write request takes precedence over a read from the same side.
            mem_write <= req_write[pick];
            mem_read  <= ~req_write[pick];
            wait_cnt  <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A response in the last allowed cycle still completes normally.
          if (mem_resp) begin
            req_rdata <= mem_rdata;
            req_resp  <= grant ? 2'b10 : 2'b01;
            state     <= S_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            req_resp <= grant ? 2'b10 : 2'b01;
            req_err  <= 1'b1;
            state    <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        S_DONE, S_ERROR: begin
          // Requests are ignored here, giving the requester this cycle to drop
          // its level-held request before IDLE looks again.
          last_grant <= grant;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A transaction-level reference model
//   predicts the winner, command, latched fields, completion time, error flag
//   and read line of each transaction. Directed cases are followed by
//   randomized traffic.
module tb_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_read, req_write;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [LINE_W-1:0] req_wdata0, req_wdata1;
  logic [1:0]        req_resp;
  logic [LINE_W-1:0] req_rdata;
  logic              req_err;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_resp(req_resp), .req_rdata(req_rdata), .req_err(req_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic              last_m;
  logic [LINE_W-1:0] rdata_m;
  int                cmd_delay;
  logic [1:0]        got_resp;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_read  = 2'b00;
    req_write = 2'b00;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    last_m  = 1'b1;
    rdata_m = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_resp"},  LINE_W'(req_resp), '0);
    chk({tag, "_err"},   LINE_W'(req_err), '0);
    chk({tag, "_mrd"},   LINE_W'(mem_read), '0);
    chk({tag, "_mwr"},   LINE_W'(mem_write), '0);
    chk({tag, "_maddr"}, LINE_W'(mem_addr), '0);
    chk({tag, "_mwd"},   mem_wdata, '0);
    chk({tag, "_rdata"}, req_rdata, '0);
  endtask

  // Serve one transaction: lat in 1..TIMEOUT is the number of WAIT cycles
  // until mem_resp; any other value means memory never answers.
  task automatic serve(input int lat);
    logic [1:0]        pend;
    int                w, n, done_at;
    bit                is_wr, err_exp;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wd, data;
    pend = req_read | req_write;
    if (pend == 2'b00) return;
    w        = (pend == 2'b11) ? (last_m ? 0 : 1) : (pend[1] ? 1 : 0);
    is_wr    = req_write[w];
    exp_addr = w ? req_addr1 : req_addr0;
    exp_wd   = w ? req_wdata1 : req_wdata0;
    got_resp = 2'b00;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_read | mem_write) && n < 8);
    cmd_delay = n;
    chk("cmd_seen", LINE_W'(mem_read | mem_write), LINE_W'(1'b1));
    if (!(mem_read | mem_write)) begin
      req_read[w]  = 1'b0;
      req_write[w] = 1'b0;
      return;
    end
    chk("cmd_write", LINE_W'(mem_write), LINE_W'(is_wr));
    chk("cmd_read",  LINE_W'(mem_read),  LINE_W'(!is_wr));
    chk("mem_addr",  LINE_W'(mem_addr),  LINE_W'(exp_addr));
    chk("mem_wdata", mem_wdata, exp_wd);

    err_exp = !(lat >= 1 && lat <= TIMEOUT);
    done_at = err_exp ? TIMEOUT + 1 : lat + 1;
    data    = rand_line();
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (req_resp != 2'b00 || n > TIMEOUT + 4) break;
      if (n == 1) chk("cmd_pulse", LINE_W'(mem_read | mem_write), '0);
      if (n == 2) begin
        // Requester changes its address/data mid-transaction.
        if (w == 1) begin req_addr1 = $urandom; req_wdata1 = rand_line(); end
        else        begin req_addr0 = $urandom; req_wdata0 = rand_line(); end
      end
      mem_resp  = (n == lat);
      mem_rdata = (n == lat) ? data : rand_line();
    end
    mem_resp = 1'b0;
    got_resp = req_resp;
    chk("resp_time", LINE_W'(n), LINE_W'(done_at));
    chk("req_resp",  LINE_W'(req_resp), LINE_W'(w == 1 ? 2'b10 : 2'b01));
    chk("req_err",   LINE_W'(req_err), LINE_W'(err_exp));
    if (!err_exp) rdata_m = data;
    chk("req_rdata", req_rdata, rdata_m);
    chk("addr_hold", LINE_W'(mem_addr), LINE_W'(exp_addr));
    chk("wdata_hold", mem_wdata, exp_wd);
    req_read[w]  = 1'b0;
    req_write[w] = 1'b0;
    last_m       = (w == 1);
    @(negedge clk);
    chk("resp_pulse", LINE_W'(req_resp), '0);
    chk("err_pulse",  LINE_W'(req_err), '0);
  endtask

  task automatic set_req(input int i, input int op);
    // op: 0 read, 1 write, 2 read+write
    if (i == 0) begin req_addr0 = $urandom; req_wdata0 = rand_line(); end
    else        begin req_addr1 = $urandom; req_wdata1 = rand_line(); end
    req_read[i]  = (op != 1);
    req_write[i] = (op != 0);
  endtask

  initial begin
    logic [1:0]        seen;
    logic              act;
    logic [LINE_W-1:0] a5;
    int                lat, pend, k;

    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    do_reset();
    chk_idle_outputs("reset");

    // Single read with 4-cycle memory latency, first grant right after reset.
    for (int i = 0; i < LINE_W / 8; i++) a5[i*8 +: 8] = 8'hA5;
    req_addr0 = 32'h100;
    req_read  = 2'b01;
    cmd_delay = 0;
    begin : single_read
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_read && n < 8);
      chk("rd_first_grant", LINE_W'(n), LINE_W'(1));
      chk("rd_mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
      chk("rd_addr", LINE_W'(mem_addr), LINE_W'(32'h100));
      n = 0;
      forever begin
        @(negedge clk);
        n++;
        if (req_resp != 2'b00 || n > 10) break;
        mem_resp  = (n == 4);
        mem_rdata = (n == 4) ? a5 : '0;
      end
      mem_resp = 1'b0;
      chk("rd_resp", LINE_W'(req_resp), LINE_W'(2'b01));
      chk("rd_rdata", req_rdata, a5);
      chk("rd_err", LINE_W'(req_err), '0);
      chk("rd_latency", LINE_W'(n), LINE_W'(5));
      req_read = 2'b00;
      rdata_m  = a5;
      last_m   = 1'b0;
      @(negedge clk);
    end

    // Tie after reset: icache, then dcache, then icache again.
    do_reset();
    set_req(0, 0); set_req(1, 0);
    serve(2);
    chk("tie_first", LINE_W'(got_resp), LINE_W'(2'b01));
    serve(3);
    chk("tie_second", LINE_W'(got_resp), LINE_W'(2'b10));
    set_req(0, 0); set_req(1, 0);
    serve(1);
    chk("tie_third", LINE_W'(got_resp), LINE_W'(2'b01));
    serve(1);

    // Write precedence on dcache.
    set_req(1, 2);
    req_wdata1 = LINE_W'(32'h1234);
    serve(2);
    chk("wp_resp", LINE_W'(got_resp), LINE_W'(2'b10));

    // Timeout, then the boundary case of mem_resp on the last WAIT cycle.
    set_req(0, 0);
    serve(0);
    set_req(0, 0);
    serve(TIMEOUT);

    // Stray mem_resp while idle.
    mem_resp  = 1'b1;
    mem_rdata = rand_line();
    @(negedge clk);
    mem_resp = 1'b0;
    seen = 2'b00; act = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | req_resp;
      act  = act | mem_read | mem_write;
    end
    chk("stray_resp", LINE_W'(seen), '0);
    chk("stray_cmd", LINE_W'(act), '0);
    chk("stray_rdata", req_rdata, rdata_m);

    // Reset two cycles after mem_read, then a late mem_resp.
    set_req(0, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_read && k < 8);
    chk("rw_cmd", LINE_W'(mem_read), LINE_W'(1'b1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; req_read = 2'b00; req_write = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("rst_wait");
    mem_resp = 1'b1; mem_rdata = rand_line();
    @(negedge clk);
    mem_resp = 1'b0;
    seen = 2'b00;
    repeat (4) begin @(negedge clk); seen = seen | req_resp; end
    chk("rw_no_resp", LINE_W'(seen), '0);
    chk("rw_rdata", req_rdata, '0);
    last_m = 1'b1; rdata_m = '0;
    set_req(1, 1);
    serve(3);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      pend = $urandom_range(1, 3);
      if (pend[0]) set_req(0, $urandom_range(0, 2));
      if (pend[1]) set_req(1, $urandom_range(0, 2));
      k = 0;
      while ((req_read | req_write) != 2'b00 && k < 3) begin
        lat = $urandom_range(0, 9);
        if (lat == 0)      lat = 0;
        else if (lat == 1) lat = TIMEOUT;
        else               lat = $urandom_range(1, 6);
        serve(lat);
        k++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
